// File: rtl/ins_buffer.sv
// Instruction buffer between fetch and decode: accepts instruction pairs,
// hands up to two instructions per cycle to decode in program order.
module ins_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push_valid,
    input  logic [0:31]                push_pc,
    input  logic [0:31]                push_ins1,
    input  logic [0:31]                push_ins2,
    output logic                       push_ready,
    input  logic [1:0]                 pop_cnt,
    output logic                       out_valid1,
    output logic                       out_valid2,
    output logic [0:31]                out_ins1,
    output logic [0:31]                out_ins2,
    output logic [0:31]                out_pc1,
    output logic [0:31]                out_pc2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       fetch_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [0:31]   r_ins [DEPTH];
    logic [0:31]   r_pc  [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_pushAcc;
    logic [1:0]    w_popReq;
    logic [1:0]    w_popEff;
    logic [AW-1:0] w_tailP1;
    logic [AW-1:0] w_headP1;
    logic [CW-1:0] w_countNext;

    // Credit comes from registered occupancy only; same-cycle pops do not help.
    assign push_ready  = (r_count <= CW'(DEPTH - 2));
    assign fetch_stall = ~push_ready;
    assign w_pushAcc   = push_valid & push_ready;

    assign w_popReq    = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
    assign w_popEff    = (CW'(w_popReq) > r_count) ? r_count[1:0] : w_popReq;

    assign w_tailP1    = r_tail + 1'b1;
    assign w_headP1    = r_head + 1'b1;
    assign w_countNext = r_count + (w_pushAcc ? CW'(2) : CW'(0)) - CW'(w_popEff);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_popEff);
            if (w_pushAcc) begin
                r_tail <= r_tail + AW'(2);
            end
            r_count <= w_countNext;
        end
    end

    // Entry storage is never cleared; validity is derived from the count alone.
    always_ff @(posedge clock) begin
        if (w_pushAcc && !reset && !flush) begin
            r_ins[r_tail]   <= push_ins1;
            r_pc[r_tail]    <= push_pc;
            r_ins[w_tailP1] <= push_ins2;
            r_pc[w_tailP1]  <= push_pc + 32'd4;
        end
    end

    assign count      = r_count;
    assign out_valid1 = (r_count >= CW'(1));
    assign out_valid2 = (r_count >= CW'(2));
    assign out_ins1   = out_valid1 ? r_ins[r_head]   : '0;
    assign out_pc1    = out_valid1 ? r_pc[r_head]    : '0;
    assign out_ins2   = out_valid2 ? r_ins[w_headP1] : '0;
    assign out_pc2    = out_valid2 ? r_pc[w_headP1]  : '0;

endmodule

// File: tb/tb_ins_buffer.sv
// Self-checking bench for ins_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_ins_buffer;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          push_valid = 1'b0;
    logic [0:31]   push_pc = '0;
    logic [0:31]   push_ins1 = '0;
    logic [0:31]   push_ins2 = '0;
    logic          push_ready;
    logic [1:0]    pop_cnt = '0;
    logic          out_valid1;
    logic          out_valid2;
    logic [0:31]   out_ins1;
    logic [0:31]   out_ins2;
    logic [0:31]   out_pc1;
    logic [0:31]   out_pc2;
    logic [CW-1:0] count;
    logic          fetch_stall;

    int total = 0;
    int bad   = 0;

    logic [31:0] modelIns [$];
    logic [31:0] modelPc  [$];

    ins_buffer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_pc    (push_pc),
        .push_ins1  (push_ins1),
        .push_ins2  (push_ins2),
        .push_ready (push_ready),
        .pop_cnt    (pop_cnt),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_ins1   (out_ins1),
        .out_ins2   (out_ins2),
        .out_pc1    (out_pc1),
        .out_pc2    (out_pc2),
        .count      (count),
        .fetch_stall(fetch_stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Model is a plain list of buffered instructions; head is element 0.
    task automatic updateModel(input logic rst, input logic fl, input logic pv,
                               input logic [31:0] pc, input logic [31:0] i1,
                               input logic [31:0] i2, input logic [1:0] pops);
        int  n;
        bit  ready;
        if (rst || fl) begin
            modelIns.delete();
            modelPc.delete();
            return;
        end
        ready = (modelIns.size() <= DEPTH - 2);
        n = (pops == 2'd3) ? 2 : int'(pops);
        if (n > modelIns.size()) n = modelIns.size();
        for (int k = 0; k < n; k++) begin
            void'(modelIns.pop_front());
            void'(modelPc.pop_front());
        end
        if (pv && ready) begin
            modelIns.push_back(i1);
            modelPc.push_back(pc);
            modelIns.push_back(i2);
            modelPc.push_back(32'(pc + 32'd4));
        end
    endtask

    task automatic checkOutput();
        int   sz;
        logic ev1, ev2;
        sz  = modelIns.size();
        ev1 = (sz >= 1);
        ev2 = (sz >= 2);
        chk("count",       64'(count),       64'(sz));
        chk("push_ready",  64'(push_ready),  64'(sz <= DEPTH - 2));
        chk("fetch_stall", 64'(fetch_stall), 64'(sz > DEPTH - 2));
        chk("out_valid1",  64'(out_valid1),  64'(ev1));
        chk("out_valid2",  64'(out_valid2),  64'(ev2));
        chk("out_ins1",    64'(out_ins1),    ev1 ? 64'(modelIns[0]) : 64'd0);
        chk("out_pc1",     64'(out_pc1),     ev1 ? 64'(modelPc[0])  : 64'd0);
        chk("out_ins2",    64'(out_ins2),    ev2 ? 64'(modelIns[1]) : 64'd0);
        chk("out_pc2",     64'(out_pc2),     ev2 ? 64'(modelPc[1])  : 64'd0);
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic pv,
                                 input logic [31:0] pc, input logic [31:0] i1,
                                 input logic [31:0] i2, input logic [1:0] pops);
        reset      = rst;
        flush      = fl;
        push_valid = pv;
        push_pc    = pc;
        push_ins1  = i1;
        push_ins2  = i2;
        pop_cnt    = pops;
        @(posedge clock);
        updateModel(rst, fl, pv, pc, i1, i2, pops);
        #1;
        reset      = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_cnt    = 2'd0;
        checkOutput();
    endtask

    initial begin
        logic [31:0] rpc;
        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        chk("rst_ready", 64'(push_ready), 64'd1);

        // First pair visible next cycle
        applyStimulus(0, 0, 1, 32'h100, 32'hAAAA0001, 32'hAAAA0002, 0);
        chk("first_pc1", 64'(out_pc1), 64'h100);
        chk("first_pc2", 64'(out_pc2), 64'h104);

        // Fill to full, fifth pair ignored, then drain two
        applyStimulus(0, 0, 1, 32'h108, 32'hBBBB0001, 32'hBBBB0002, 0);
        applyStimulus(0, 0, 1, 32'h110, 32'hCCCC0001, 32'hCCCC0002, 0);
        applyStimulus(0, 0, 1, 32'h118, 32'hDDDD0001, 32'hDDDD0002, 0);
        chk("full_count", 64'(count), 64'd8);
        applyStimulus(0, 0, 1, 32'h120, 32'hEEEE0001, 32'hEEEE0002, 0);
        chk("ignored_count", 64'(count), 64'd8);
        applyStimulus(0, 0, 1, 32'h120, 32'hEEEE0001, 32'hEEEE0002, 2);
        chk("drain_count", 64'(count), 64'd6);

        // Down to three, then push with single pop
        applyStimulus(0, 0, 0, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 32'h300, 32'h11110001, 32'h11110002, 1);
        chk("pushpop_count", 64'(count), 64'd4);

        // Single entry with over-request of two
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h400, 32'h22220001, 32'h22220002, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 2);
        chk("underflow_ins1", 64'(out_ins1), 64'd0);

        // Wrap the pointers, reach five, flush with push and pop
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 32'h500 + 32'(k * 8), 32'h3000 + 32'(k), 32'h4000 + 32'(k), 2);
        end
        applyStimulus(0, 0, 1, 32'h600, 32'h55550001, 32'h55550002, 0);
        applyStimulus(0, 0, 1, 32'h608, 32'h55550003, 32'h55550004, 1);
        chk("wrap_count", 64'(count), 64'd5);
        applyStimulus(0, 1, 1, 32'h700, 32'h66660001, 32'h66660002, 2);
        chk("flush_valid1", 64'(out_valid1), 64'd0);

        // Reset beats flush with a push pending at count six
        applyStimulus(0, 0, 1, 32'h800, 1, 2, 0);
        applyStimulus(0, 0, 1, 32'h808, 3, 4, 0);
        applyStimulus(0, 0, 1, 32'h810, 5, 6, 0);
        applyStimulus(1, 1, 1, 32'h818, 7, 8, 2);
        applyStimulus(0, 0, 1, 32'h200, 32'h77770001, 32'h77770002, 0);
        chk("after_rst_pc1", 64'(out_pc1), 64'h200);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rpc = $urandom & 32'hFFFF_FFFC;
            if (k == 50) rpc = 32'hFFFF_FFFC;
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(31) == 0),
                          1'($urandom_range(1)), rpc, $urandom, $urandom,
                          2'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
